// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clock-gated ALU between two requesters.
// Optional WAIT-state timeout abort enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
   parameter int unsigned D_WIDTH = 8,
   parameter int unsigned TMO_CYC = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0,
   input  logic [3:0]             fun0,
   input  logic                   req1,
   input  logic [3:0]             fun1,
   output logic                   gnt0,
   output logic                   gnt1,
   output logic [2*D_WIDTH-1:0]   res_data,
   output logic                   res_valid,
   output logic                   res_id,
   output logic                   alu_en,
   output logic [3:0]             alu_fun,
   input  logic [2*D_WIDTH-1:0]   alu_out,
   input  logic                   out_valid,
   output logic                   gate_en,
   output logic                   err_tmo
);

   localparam int unsigned RES_W = 2 * D_WIDTH;
   localparam int unsigned FUN_W = 4;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAKE = 3'd1;
   localparam logic [2:0] ST_EXEC = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   if ((TMO_CYC < 1) || (TMO_CYC > 255)) begin : g_tmo_range
      $error("alu_arbiter: TMO_CYC must be within 1..255");
   end

   logic [2:0]       state_q, state_nxt;
   logic             owner_q, owner_nxt;
   logic [FUN_W-1:0] fun_q, fun_nxt;
   logic             last_q, last_nxt;

   logic             gnt0_nxt, gnt1_nxt;
   logic [RES_W-1:0] res_data_nxt;
   logic             res_valid_nxt, res_id_nxt;
   logic             alu_en_nxt;
   logic [FUN_W-1:0] alu_fun_nxt;
   logic             gate_en_nxt, err_tmo_nxt;
   logic             win_c;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
   logic [7:0]       tmo_cnt_q, tmo_cnt_nxt;
`endif

   // Tie goes to the requester that was not served last.
   assign win_c = (req0 && req1) ? ~last_q : req1;

   // State, owner and round-robin bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         fun_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_nxt;
         owner_q <= owner_nxt;
         fun_q   <= fun_nxt;
         last_q  <= last_nxt;
      end
   end

`ifdef ALU_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_nxt;
      end
   end
`endif

   // Next state plus look-ahead values for the registered outputs.
   always_comb begin
      state_nxt     = state_q;
      owner_nxt     = owner_q;
      fun_nxt       = fun_q;
      last_nxt      = last_q;
      gnt0_nxt      = 1'b0;
      gnt1_nxt      = 1'b0;
      res_data_nxt  = res_data;
      res_valid_nxt = 1'b0;
      res_id_nxt    = res_id;
      alu_en_nxt    = 1'b0;
      alu_fun_nxt   = '0;
      gate_en_nxt   = 1'b0;
      err_tmo_nxt   = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt_nxt   = tmo_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // A grant still visible here is a timeout abort; its request is stale.
            if ((req0 || req1) && !(gnt0 || gnt1)) begin
               owner_nxt   = win_c;
               fun_nxt     = win_c ? fun1 : fun0;
               state_nxt   = ST_WAKE;
               gate_en_nxt = 1'b1;
            end
         end
         ST_WAKE: begin
            state_nxt   = ST_EXEC;
            gate_en_nxt = 1'b1;
            alu_en_nxt  = 1'b1;
            alu_fun_nxt = fun_q;
         end
         ST_EXEC: begin
            state_nxt   = ST_WAIT;
            gate_en_nxt = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
         end
         ST_WAIT: begin
            if (out_valid) begin
               state_nxt     = ST_DONE;
               res_data_nxt  = alu_out;
               res_valid_nxt = 1'b1;
               res_id_nxt    = owner_q;
               gnt0_nxt      = ~owner_q;
               gnt1_nxt      = owner_q;
               last_nxt      = owner_q;
            end else begin
               gate_en_nxt = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
               if (tmo_cnt_q == TMO_LAST) begin
                  state_nxt   = ST_IDLE;
                  gate_en_nxt = 1'b0;
                  err_tmo_nxt = 1'b1;
                  gnt0_nxt    = ~owner_q;
                  gnt1_nxt    = owner_q;
                  last_nxt    = owner_q;
               end else begin
                  tmo_cnt_nxt = tmo_cnt_q + 8'd1;
               end
`endif
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         res_data  <= '0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         alu_en    <= 1'b0;
         alu_fun   <= '0;
         gate_en   <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         gnt0      <= gnt0_nxt;
         gnt1      <= gnt1_nxt;
         res_data  <= res_data_nxt;
         res_valid <= res_valid_nxt;
         res_id    <= res_id_nxt;
         alu_en    <= alu_en_nxt;
         alu_fun   <= alu_fun_nxt;
         gate_en   <= gate_en_nxt;
         err_tmo   <= err_tmo_nxt;
      end
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 8: ALU operand width; result width is 2*D_WIDTH.
REQ-002 Parameter TMO_CYC, default 15: maximum WAIT cycles before abort; range 1..255.
REQ-003 CLK  in  1  single clock, rising edge; shares the REF_CLK domain with the ALU.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 REQ0  in  1  requester 0 operation request; level, held until GNT0.
REQ-006 FUN0  in  4  requester 0 ALU function code; stable while REQ0=1.
REQ-007 REQ1  in  1  requester 1 operation request; level, held until GNT1.
REQ-008 FUN1  in  4  requester 1 ALU function code; stable while REQ1=1.
REQ-009 GNT0 / GNT1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-010 RES_DATA  out  2*D_WIDTH  captured ALU result.
REQ-011 RES_VALID  out  1  one-cycle pulse qualifying RES_DATA.
REQ-012 RES_ID  out  1  owner of the current RES_DATA (0/1).
REQ-013 ALU_En  out  1  ALU enable, one-cycle pulse.
REQ-014 ALU_FUN  out  4  function code to the ALU.
REQ-015 ALU_OUT  in  2*D_WIDTH  ALU result.
REQ-016 OUT_Valid  in  1  ALU result valid.
REQ-017 Gate_En  out  1  ALU clock-gate enable.
REQ-018 ERR_TMO  out  1  one-cycle timeout-abort pulse.

Function
REQ-019 FSM states: IDLE, WAKE, EXEC, WAIT, DONE; all outputs are registered.
REQ-020 IDLE: if any REQ is high, latch the winner (owner) and its FUN, then go to WAKE; otherwise stay in IDLE.
REQ-021 Arbitration: round-robin; the last-served bit selects which requester has priority when both requests are high; the bit toggles to the owner in DONE.
REQ-022 WAKE: Gate_En=1; next state is EXEC (one cycle of clock wake-up before use).
REQ-023 EXEC: ALU_En=1 and ALU_FUN=latched FUN for exactly one cycle; next state is WAIT.
REQ-024 WAIT: Gate_En stays 1; when OUT_Valid=1, capture ALU_OUT into RES_DATA and go to DONE.
REQ-025 DONE: RES_VALID=1, RES_ID=owner, GNT[owner]=1 for one cycle; Gate_En=0; next state is IDLE.
REQ-026 Latency: from the REQ sample edge to RES_VALID is 4 cycles when OUT_Valid arrives in the first WAIT cycle.
REQ-027 A REQ deasserted before its GNT is ignored: the operation completes, and GNT is still issued.
REQ-028 OUT_Valid outside WAIT is ignored; RES_DATA holds its last value.
REQ-029 A request arriving in DONE is sampled on the following IDLE cycle, so there is a minimum 1 idle cycle between operations.
REQ-030 Gate_En=1 only in WAKE, EXEC and WAIT.

Reset
REQ-031 Asynchronous reset forces IDLE, last-served=1 (requester 0 wins the first tie), RES_DATA=0, RES_ID=0, and all pulse outputs, Gate_En, ALU_En and ALU_FUN to 0.
REQ-032 Reset mid-operation abandons the operation with no GNT; the requester re-requests after reset.

Configuration
REQ-033 Macro ALU_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without OUT_Valid; when it reaches TMO_CYC, the block pulses ERR_TMO and GNT[owner], leaves RES_VALID=0 and RES_DATA unchanged, and goes to IDLE.
REQ-034 Macro undefined: no counter; WAIT is exited only on OUT_Valid, and ERR_TMO is tied to 0.

Verification
REQ-035 Single request: REQ0=1, FUN0=4'h0, ALU returns 16'h0012 on the first WAIT cycle -> RES_VALID and GNT0 at cycle 4, RES_DATA=16'h0012, RES_ID=0.
REQ-036 Tie after reset: REQ0=REQ1=1 held -> owners in order 0,1,0,1; each GNT is one cycle; no ALU_En overlap.
REQ-037 Clock gating: one operation -> Gate_En high for exactly 3 cycles (WAKE, EXEC, first WAIT) before DONE; ALU_En high exactly 1 cycle.
REQ-038 Timeout (ALU_ARB_TIMEOUT_EN, TMO_CYC=3): OUT_Valid never asserted -> ERR_TMO and GNT0 after 3 WAIT cycles; RES_VALID stays 0.
REQ-039 Reset in WAIT: RST low for 1 cycle -> all outputs 0 immediately; no GNT; the next REQ1 is served normally.
REQ-040 Spurious OUT_Valid in IDLE with ALU_OUT=16'hFFFF -> no RES_VALID; RES_DATA unchanged.
